// File: rtl/mod_serial_accumulator_pkg.sv
// Shared types and constants for the bit-serial modular accumulator.
package mod_acc_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, CORRECT, HOLD} state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 13;

  // Bit counter must hold values up to WIDTH.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mod_serial_accumulator_if.sv
// Request/result handshake bundle for mod_serial_accumulator.
interface mod_serial_accumulator_if #(
  parameter int WIDTH = mod_acc_pkg::DEF_WIDTH
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] acc_out;
  logic             range_err;

  modport master (
    output clear, in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, acc_out, range_err
  );

  modport slave (
    input  clear, in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, acc_out, range_err
  );
endinterface

// File: rtl/mod_serial_accumulator_bit.sv
// One-bit serial full adder / subtractor with a registered carry (add) or borrow (sub).
module serial_addsub_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic sub,
  input  logic init,
  input  logic en,
  output logic sum,
  output logic carry_out
);
  logic c_nxt;

  assign sum   = a ^ b ^ carry_out;
  assign c_nxt = sub ? ((~a & b) | (~(a ^ b) & carry_out))
                     : ((a & b)  | ((a ^ b) & carry_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    carry_out <= 1'b0;
    else if (init) carry_out <= 1'b0;
    else if (en)   carry_out <= c_nxt;
  end
endmodule

// File: rtl/mod_serial_accumulator.sv
// Bit-serial modular accumulator: ACC = (ACC +/- x) mod MODULUS, LSB-first, one correction cycle.
// Optional MOD_ACC_WRAP_COUNT_EN adds a saturating count of corrected commits.
module mod_serial_accumulator
  import mod_acc_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MOD_ACC_WRAP_COUNT_EN
  output logic [7:0] wrap_count,
`endif
  mod_serial_accumulator_if.slave bus
);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MOD_LO = MOD_W[WIDTH-1:0];
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] acc_q, work_sr, x_sr, result;
  logic [CNT_W-1:0] bit_cnt;
  logic             op_q, out_valid_q, in_ready_q, range_err_q;
  logic             accept, sum_bit, carry_out, corr_fire;
  logic [WIDTH:0]   raw;

  assign accept = (state == IDLE) && bus.in_valid && !bus.clear;

  serial_addsub_bit u_bit (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (work_sr[0]),
    .b         (x_sr[0]),
    .sub       (op_q),
    .init      (accept | bus.clear),
    .en        (state == SHIFT),
    .sum       (sum_bit),
    .carry_out (carry_out)
  );

  // After the last shift work_sr holds the raw sum/difference, carry_out the carry/borrow.
  assign raw       = {carry_out, work_sr};
  assign corr_fire = (op_q == OP_ADD) ? (raw >= MOD_W) : carry_out;

  always_comb begin
    result = work_sr;
    if (corr_fire)
      result = (op_q == OP_ADD) ? WIDTH'(raw - MOD_W) : (work_sr + MOD_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc_q       <= '0;
      work_sr     <= '0;
      x_sr        <= '0;
      op_q        <= OP_ADD;
      bit_cnt     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      range_err_q <= 1'b0;
    end else if (bus.clear) begin
      state       <= IDLE;
      acc_q       <= '0;
      bit_cnt     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      range_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_q        <= bus.in_op;
          x_sr        <= bus.in_data;
          work_sr     <= acc_q;
          range_err_q <= ({1'b0, bus.in_data} >= MOD_W);
          bit_cnt     <= '0;
          in_ready_q  <= 1'b0;
          state       <= SHIFT;
        end
        SHIFT: begin
          work_sr <= {sum_bit, work_sr[WIDTH-1:1]};
          x_sr    <= {x_sr[0], x_sr[WIDTH-1:1]};
          if (bit_cnt == LAST) begin
            bit_cnt <= '0;
            state   <= CORRECT;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        CORRECT: begin
          if (!range_err_q) acc_q <= result;
          out_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MOD_ACC_WRAP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wrap_count <= '0;
    else if (bus.clear) wrap_count <= '0;
    else if (state == CORRECT && !range_err_q && corr_fire && wrap_count != 8'hFF)
      wrap_count <= wrap_count + 8'd1;
  end
`endif

  assign bus.acc_out   = acc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.range_err = range_err_q;
endmodule

// File: tb/tb_mod_serial_accumulator.sv
// Randomized + directed bench for mod_serial_accumulator against a plain-arithmetic residue model.
module tb_mod_serial_accumulator;
  localparam int W = 4;
  localparam int M = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod_serial_accumulator_if #(.WIDTH(W)) bus();
`ifdef MOD_ACC_WRAP_COUNT_EN
  logic [7:0] wrap_count;
`endif

  mod_serial_accumulator #(.WIDTH(W), .MODULUS(M)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef MOD_ACC_WRAP_COUNT_EN
    .wrap_count (wrap_count),
`endif
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;
  int acc_m = 0;
  int wrap_m = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_wrap();
`ifdef MOD_ACC_WRAP_COUNT_EN
    chk("wrap_count", int'(wrap_count), wrap_m);
`endif
  endtask

  // Starts and ends just after a falling edge with the DUT idle.
  task automatic run_req(input bit op, input int x, input int bp);
    int n;
    int old;
    bit err;
    old = acc_m;
    err = (x >= M);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = W'(x);
    chk("idle_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    bus.in_op    = 1'($urandom);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) break;
      chk("acc_stable", int'(bus.acc_out), old);
      chk("busy_ready", int'(bus.in_ready), 0);
    end
    chk("latency", n, W + 2);
    if (!err) begin
      if (op == 1'b0) begin
        if (acc_m + x >= M && wrap_m < 255) wrap_m++;
        acc_m = (acc_m + x) % M;
      end else begin
        if (x > acc_m && wrap_m < 255) wrap_m++;
        acc_m = (acc_m - x + M) % M;
      end
    end
    chk("acc", int'(bus.acc_out), acc_m);
    chk("range_err", int'(bus.range_err), int'(err));
    chk_wrap();
    for (int k = 0; k < bp; k++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = W'($urandom);
      @(negedge clk);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_ready", int'(bus.in_ready), 0);
      chk("hold_acc", int'(bus.acc_out), acc_m);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("drain_valid", int'(bus.out_valid), 0);
    chk("drain_ready", int'(bus.in_ready), 1);
  endtask

  initial begin
    int n;
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_op = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_acc", int'(bus.acc_out), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_ready", int'(bus.in_ready), 1);
    chk("rst_err", int'(bus.range_err), 0);
    chk_wrap();

    // Directed arithmetic corners for M=13.
    run_req(1'b0, 7, 0);
    run_req(1'b0, 9, 0);
    run_req(1'b1, 5, 0);
    run_req(1'b1, 11, 0);
    run_req(1'b0, 0, 0);
    run_req(1'b0, 12, 0);
    run_req(1'b0, 12, 0);
    run_req(1'b0, 1, 0);
    run_req(1'b0, 1, 0);
    run_req(1'b0, 13, 0);
    run_req(1'b1, 15, 0);
    run_req(1'b0, 1, 5);

    for (int i = 0; i < 40; i++)
      run_req(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));

    // Clear mid-SHIFT wins over a simultaneous request.
    run_req(1'b0, 5, 0);
    bus.in_valid = 1'b1; bus.in_op = 1'b0; bus.in_data = W'(3);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = W'(4);
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    acc_m = 0; wrap_m = 0;
    @(negedge clk);
    chk("clr_acc", int'(bus.acc_out), 0);
    chk("clr_valid", int'(bus.out_valid), 0);
    chk("clr_ready", int'(bus.in_ready), 1);
    chk("clr_err", int'(bus.range_err), 0);
    chk_wrap();
    repeat (8) begin
      @(negedge clk);
      chk("clr_no_accept", int'(bus.out_valid), 0);
    end
    run_req(1'b0, 2, 0);

    // Async reset while holding an out-of-range result.
    bus.in_valid = 1'b1; bus.in_op = 1'b0; bus.in_data = W'(14);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (n < 20 && !bus.out_valid) begin
      @(negedge clk);
      n++;
    end
    chk("rst_hold_reached", int'(bus.out_valid), 1);
    chk("rst_hold_err", int'(bus.range_err), 1);
    #2 rst_n = 1'b0;
    #1;
    acc_m = 0; wrap_m = 0;
    chk("arst_valid", int'(bus.out_valid), 0);
    chk("arst_acc", int'(bus.acc_out), 0);
    chk("arst_ready", int'(bus.in_ready), 1);
    chk("arst_err", int'(bus.range_err), 0);
    chk_wrap();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_req(1'b1, 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
